config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Sequences the CGRA serial configuration chain: a chain of shift cells linked ConfigIn to ConfigOut, where each cell shifts right and takes its new MSB from ConfigIn.
- Accepts WORD_W-bit configuration words over a valid/ready stream from the host interface and serialises exactly CHAIN_LEN bits into the head of the chain, gated by a shift enable.
- Captures the bits falling out of the chain tail and repacks them into readback words, so software can verify the previous configuration or daisy-chain integrity.
- Sits between the RoCC/stream front end and the chain, in the Config_Clock domain.

Parameters:
- WORD_W, 32, width of host words and readback words.
- CHAIN_LEN, 64, total configuration bits in the chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the total bit counter.

Ports:
- Config_Clock  in  1  sole clock; chain cells use the same clock, qualified by cfg_shift_en.
- Config_Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load; ignored unless idle.
- word_valid  in  1  host word available.
- word_data  in  WORD_W  host word; bit 0 is shifted first.
- word_ready  out  1  loader accepts word_data this cycle.
- cfg_bit  out  1  drives ConfigIn of the first chain cell.
- cfg_shift_en  out  1  chain shifts on this clock edge.
- chain_out  in  1  ConfigOut of the last chain cell.
- readback_valid  out  1  one-cycle pulse: readback_data valid.
- readback_data  out  WORD_W  captured tail bits, first-out bit at bit 0.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.

Behaviour:
- Reset (async, any state): state=IDLE; word_ready, cfg_shift_en, cfg_bit, readback_valid, busy, done = 0; readback_data=0; all counters and shift registers = 0.
- Reset mid-load leaves chain contents undefined; software must restart the load.
- FSM states: IDLE, WAIT_WORD, SHIFT, FINISH.
- IDLE: start=1 -> WAIT_WORD; total_cnt=0; busy=1 from the next cycle.
- WAIT_WORD: word_ready=1 (combinational from state). On word_valid&&word_ready: shreg<=word_data, word_bit=0 -> SHIFT. No shifting while waiting, so host stalls are harmless.
- SHIFT, each cycle:
  - cfg_shift_en=1 and cfg_bit=shreg[0]; both combinational from state and shreg, so the chain samples them on the same edge.
  - On that edge: shreg>>=1, word_bit++, total_cnt++, and chain_out (the pre-shift tail bit) enters the readback deserialiser.
- SHIFT exit, evaluated on the cycle whose edge shifts the last bit:
  - total_cnt==CHAIN_LEN-1 -> FINISH.
  - Else word_bit==WORD_W-1 -> WAIT_WORD.
- Last-word truncation: the last word supplies CHAIN_LEN mod WORD_W bits (WORD_W if that is 0); its upper bits are discarded. Word count = ceil(CHAIN_LEN/WORD_W); extra host words are not accepted.
- FINISH: done=1 for one cycle, busy=0 next cycle -> IDLE. start during FINISH is ignored.
- Outside SHIFT: cfg_shift_en=0, cfg_bit=0.
- Readback:
  - Captured bit k goes into readback_data bit (k mod WORD_W).
  - readback_valid pulses the cycle after WORD_W bits have been collected, or the cycle after the final shift with a partial word zero-padded in the upper bits.
  - No backpressure; data holds until the next pulse.
  - On the final shift, readback_valid and done are asserted in the same cycle (FINISH).
- Latency: start to first word_ready = 1 cycle; a word handshake to its first shift = 1 cycle; minimum load = CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 2 cycles.
- start while busy is ignored; word_valid outside WAIT_WORD is ignored.

Decomposition:
- Package config_chain_pkg holds:
  - the state enum (IDLE, WAIT_WORD, SHIFT, FINISH);
  - the localparam function computing the word count;
  - the last-word bit count.
- One sub-module: cfg_readback_deser. It is a 1-bit-in, WORD_W-out deserialiser with inputs bit_in, bit_en and flush, and outputs data and valid.

Test Plan:
- CHAIN_LEN=64, WORD_W=32, words 0xA5A5_0F0F then 0x1234_5678 with valid held -> exactly 64 cfg_shift_en cycles, 32+32 split by one WAIT_WORD cycle; cfg_bit sequence is LSB-first of each word; done pulses once; a 64-cell ConfigCell chain model holds the expected pattern.
- CHAIN_LEN=40, WORD_W=32, words 0xFFFF_FFFF, 0xFFFF_FF3C -> 32+8 shifts; bits 8..31 of the second word are never emitted; the third word_valid is not accepted.
- Chain model preloaded with 0xDEAD_BEEF_CAFE_F00D, then a reload -> readback words 0xCAFE_F00D then 0xDEAD_BEEF, each with a single readback_valid pulse; the second pulse coincides with done.
- Host deasserts word_valid for 5 cycles between words -> cfg_shift_en stays 0 for those cycles, chain contents are unchanged, busy=1 throughout.
- start pulsed during SHIFT and during FINISH -> no second load; a start after done returns to IDLE and begins a new load normally.
- Config_Reset asserted asynchronously mid-SHIFT (bit 17) -> all outputs 0 immediately, state IDLE; a following start performs a full clean 64-bit load.

Source files
------------

// File: rtl/config_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package config_chain_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        FINISH    = 2'd3
    } state_t;

    // Host words needed to fill a chain of chain_len bits.
    function automatic int word_count(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits taken from the final host word; its upper bits are dropped.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Host stream, chain head/tail and status signals of the configuration loader.
interface config_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              cfg_bit;
    logic              cfg_shift_en;
    logic              chain_out;
    logic              readback_valid;
    logic [WORD_W-1:0] readback_data;
    logic              busy;
    logic              done;

    modport master (
        output start, word_valid, word_data, chain_out,
        input  word_ready, cfg_bit, cfg_shift_en, readback_valid, readback_data, busy, done
    );

    modport slave (
        input  start, word_valid, word_data, chain_out,
        output word_ready, cfg_bit, cfg_shift_en, readback_valid, readback_data, busy, done
    );
endinterface

// File: rtl/config_chain_loader_readback_deser.sv
// Packs the bits leaving the chain tail into words, first bit at bit 0;
// flush closes a partial word with zeros in the unfilled upper bits.
module cfg_readback_deser
    import config_chain_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              bit_in,
    input  logic              bit_en,
    input  logic              flush,
    output logic [WORD_W-1:0] data,
    output logic              valid
);
    localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_data;
    logic [CW-1:0]     r_cnt;
    logic              r_valid;
    logic [WORD_W-1:0] w_acc_next;
    logic              w_word_full;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_ins
            assign w_acc_next[gi] = (r_cnt == CW'(gi)) ? bit_in : r_acc[gi];
        end
    endgenerate

    assign w_word_full = (r_cnt == CW'(WORD_W - 1));

    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            r_acc   <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bit_en) begin
                if (flush || w_word_full) begin
                    r_data  <= w_acc_next;
                    r_valid <= 1'b1;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign data  = r_data;
    assign valid = r_valid;

endmodule

// File: rtl/config_chain_loader.sv
// Streams host words LSB-first into the serial config chain, CHAIN_LEN bits in
// total, while the displaced tail bits are repacked into readback words.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic Config_Clock,
    input  logic Config_Reset,
    config_chain_loader_if.slave bus
);
    localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [WORD_W-1:0] r_shreg;
    logic [WB_W-1:0]   r_word_bit;
    logic [CNT_W-1:0]  r_total_cnt;

    logic w_word_ready;
    logic w_shift_en;
    logic w_cfg_bit;
    logic w_done;
    logic w_last_shift;
    logic w_word_end;

    assign w_last_shift = (r_total_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_word_end   = (r_word_bit == WB_W'(WORD_W - 1));

    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Chain-facing strobes are combinational so the cells sample them on the
    // same edge that advances the shift register.
    always_comb begin
        w_next_state = r_state;
        w_word_ready = 1'b0;
        w_shift_en   = 1'b0;
        w_cfg_bit    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next_state = WAIT_WORD;
            end
            WAIT_WORD: begin
                w_word_ready = 1'b1;
                if (bus.word_valid) w_next_state = SHIFT;
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                w_cfg_bit  = r_shreg[0];
                if (w_last_shift)    w_next_state = FINISH;
                else if (w_word_end) w_next_state = WAIT_WORD;
            end
            FINISH: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            r_shreg     <= '0;
            r_word_bit  <= '0;
            r_total_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) r_total_cnt <= '0;
                end
                WAIT_WORD: begin
                    if (bus.word_valid) begin
                        r_shreg    <= bus.word_data;
                        r_word_bit <= '0;
                    end
                end
                SHIFT: begin
                    r_shreg     <= r_shreg >> 1;
                    r_word_bit  <= r_word_bit + 1'b1;
                    r_total_cnt <= r_total_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    cfg_readback_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .Config_Clock (Config_Clock),
        .Config_Reset (Config_Reset),
        .bit_in       (bus.chain_out),
        .bit_en       (w_shift_en),
        .flush        (w_shift_en && w_last_shift),
        .data         (bus.readback_data),
        .valid        (bus.readback_valid)
    );

    assign bus.word_ready   = w_word_ready;
    assign bus.cfg_shift_en = w_shift_en;
    assign bus.cfg_bit      = w_cfg_bit;
    assign bus.done         = w_done;
    assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench: a 64-cell and a 40-cell chain model, directed host words,
// expected cfg bits and readback words queued at issue time and checked by monitors.
module tb_config_chain_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    config_chain_loader_if #(.WORD_W(32)) ifa ();
    config_chain_loader_if #(.WORD_W(32)) ifb ();

    config_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) dut_a (
        .Config_Clock (clk),
        .Config_Reset (rst),
        .bus          (ifa)
    );

    config_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut_b (
        .Config_Clock (clk),
        .Config_Reset (rst),
        .bus          (ifb)
    );

    // Chain models: every cell shifts right, MSB cell takes ConfigIn.
    logic [63:0] chain_a, pre_a_val;
    logic [39:0] chain_b, pre_b_val;
    logic        pre_a_en = 1'b0, pre_b_en = 1'b0;

    always @(posedge clk) begin
        if (pre_a_en)              chain_a <= pre_a_val;
        else if (ifa.cfg_shift_en) chain_a <= {ifa.cfg_bit, chain_a[63:1]};
        if (pre_b_en)              chain_b <= pre_b_val;
        else if (ifb.cfg_shift_en) chain_b <= {ifb.cfg_bit, chain_b[39:1]};
    end
    assign ifa.chain_out = chain_a[0];
    assign ifb.chain_out = chain_b[0];

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } rb_t;

    logic bits_a[$];
    logic bits_b[$];
    rb_t  rb_a[$];
    rb_t  rb_b[$];

    int n_cmp = 0;
    int n_bad = 0;
    int shifts_a = 0, dones_a = 0, readies_a = 0;
    int shifts_b = 0, dones_b = 0, accepts_b = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endfunction

    // Monitors: pop the expected value whenever the DUT presents an output.
    always @(negedge clk) begin
        rb_t ea;
        if (!rst) begin
            if (ifa.cfg_shift_en) begin
                shifts_a++;
                if (bits_a.size() == 0) check("a_cfg_bit_unexpected", 1, 0);
                else check("a_cfg_bit", ifa.cfg_bit, bits_a.pop_front());
            end
            if (ifa.readback_valid) begin
                if (rb_a.size() == 0) check("a_readback_unexpected", 1, 0);
                else begin
                    ea = rb_a.pop_front();
                    check("a_readback_data", ifa.readback_data, ea.d);
                    check("a_readback_with_done", ifa.done, ea.last);
                end
            end
            if (ifa.done)       dones_a++;
            if (ifa.word_ready) readies_a++;
        end
    end

    always @(negedge clk) begin
        rb_t eb;
        if (!rst) begin
            if (ifb.cfg_shift_en) begin
                shifts_b++;
                if (bits_b.size() == 0) check("b_cfg_bit_unexpected", 1, 0);
                else check("b_cfg_bit", ifb.cfg_bit, bits_b.pop_front());
            end
            if (ifb.readback_valid) begin
                if (rb_b.size() == 0) check("b_readback_unexpected", 1, 0);
                else begin
                    eb = rb_b.pop_front();
                    check("b_readback_data", ifb.readback_data, eb.d);
                    check("b_readback_with_done", ifb.done, eb.last);
                end
            end
            if (ifb.done) dones_b++;
            if (ifb.word_valid && ifb.word_ready) accepts_b++;
        end
    end

    task automatic check_idle_a(input string tag);
        check({tag, "_ctl"}, {ifa.word_ready, ifa.cfg_shift_en, ifa.cfg_bit,
                              ifa.readback_valid, ifa.busy, ifa.done}, 0);
        check({tag, "_rbdata"}, ifa.readback_data, 0);
    endtask

    task automatic a_preload(input logic [63:0] v);
        pre_a_val = v; pre_a_en = 1'b1;
        @(posedge clk); #1;
        pre_a_en = 1'b0;
    endtask

    task automatic a_start();
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        check("a_start_to_ready", {ifa.busy, ifa.word_ready}, 2'b11);
    endtask

    // Offers a word (valid left high) and returns just after the accepting edge.
    task automatic a_send(input logic [31:0] w, input int nbits);
        int t = 0;
        for (int i = 0; i < nbits; i++) bits_a.push_back(w[i]);
        ifa.word_data  = w;
        ifa.word_valid = 1'b1;
        while (!ifa.word_ready && t < 500) begin @(negedge clk); t++; end
        if (!ifa.word_ready) check("a_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic a_wait_done(input bit fin_start);
        int t = 0;
        @(negedge clk);
        while (!ifa.done && t < 500) begin @(negedge clk); t++; end
        check("a_done_seen", ifa.done, 1);
        if (fin_start) ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        check("a_busy_after_done", ifa.busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("a_stays_idle", {ifa.busy, ifa.word_ready}, 0);
    endtask

    task automatic a_load(input logic [31:0] w0, input logic [31:0] w1, input logic [63:0] prior,
                          input int gap, input bit mid_start, input bit fin_start);
        int s0 = shifts_a, d0 = dones_a, r0 = readies_a, t = 0;
        rb_a.push_back({prior[31:0], 1'b0});
        rb_a.push_back({prior[63:32], 1'b1});
        a_start();
        a_send(w0, 32);
        if (mid_start) begin
            repeat (3) @(posedge clk);
            #1 ifa.start = 1'b1;
            @(posedge clk); #1;
            ifa.start = 1'b0;
        end
        if (gap > 0) begin
            ifa.word_valid = 1'b0;
            while (!ifa.word_ready && t < 500) begin @(negedge clk); t++; end
            for (int g = 0; g < gap; g++) begin
                if (g > 0) @(negedge clk);
                check("a_gap_no_shift", ifa.cfg_shift_en, 0);
                check("a_gap_busy", ifa.busy, 1);
                check("a_gap_chain", chain_a, {w0, prior[63:32]});
            end
            @(posedge clk); #1;
        end
        a_send(w1, 32);
        ifa.word_valid = 1'b0;
        a_wait_done(fin_start);
        check("a_shift_count", shifts_a - s0, 64);
        check("a_done_count", dones_a - d0, 1);
        check("a_wait_cycles", readies_a - r0, 2 + gap);
        check("a_chain", chain_a, {w1, w0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s0;
        ifa.start = 1'b0; ifa.word_valid = 1'b0; ifa.word_data = '0;
        ifb.start = 1'b0; ifb.word_valid = 1'b0; ifb.word_data = '0;
        pre_a_val = '0; pre_b_val = '0;

        a_preload(64'h0);
        pre_b_val = 40'hA5_1234_5678; pre_b_en = 1'b1;
        @(posedge clk); #1;
        pre_b_en = 1'b0;
        check_idle_a("reset_a_held");
        check("reset_b_held", {ifb.word_ready, ifb.cfg_shift_en, ifb.busy, ifb.done, ifb.readback_valid}, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_idle_a("reset_a_released");

        // Back-to-back words, valid held.
        a_load(32'hA5A5_0F0F, 32'h1234_5678, 64'h0, 0, 1'b0, 1'b0);
        // Readback of a known prior configuration.
        a_preload(64'hDEAD_BEEF_CAFE_F00D);
        a_load(32'h0BAD_F00D, 32'h5EED_1234, 64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0, 1'b0);
        // Host stall of 5 cycles between words.
        a_load(32'h1357_9BDF, 32'h2468_ACE0, 64'h5EED_1234_0BAD_F00D, 5, 1'b0, 1'b0);
        // start during SHIFT and FINISH is ignored.
        a_load(32'hFEED_C0DE, 32'h00FF_00FF, 64'h2468_ACE0_1357_9BDF, 0, 1'b1, 1'b1);
        // A start after done begins a new load normally.
        a_load(32'h8000_0001, 32'h7FFF_FFFE, 64'h00FF_00FF_FEED_C0DE, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the first word.
        s0 = shifts_a; t = 0;
        a_start();
        a_send(32'h55AA_55AA, 32);
        while ((shifts_a - s0) < 17 && t < 200) begin @(negedge clk); #1; t++; end
        check("a_reached_bit17", shifts_a - s0, 17);
        #2 rst = 1'b1;
        #1;
        check_idle_a("async_reset_mid_shift");
        ifa.word_valid = 1'b0;
        bits_a.delete();
        rb_a.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        a_preload(64'h0123_4567_89AB_CDEF);
        a_load(32'hC001_D00D, 32'hBEEF_0001, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b0);

        // 40-bit chain: second word truncated to 8 bits, third word refused.
        rb_b.push_back({32'h1234_5678, 1'b0});
        rb_b.push_back({32'h0000_00A5, 1'b1});
        for (int i = 0; i < 32; i++) bits_b.push_back(1'b1);
        for (int i = 0; i < 8; i++) bits_b.push_back(i inside {2, 3, 4, 5});
        s0 = shifts_b;
        ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        ifb.word_data = 32'hFFFF_FFFF; ifb.word_valid = 1'b1;
        for (int w = 0; w < 2; w++) begin
            t = 0;
            while (!ifb.word_ready && t < 500) begin @(negedge clk); t++; end
            check("b_ready_seen", ifb.word_ready, 1);
            @(posedge clk); #1;
            ifb.word_data = (w == 0) ? 32'hFFFF_FF3C : 32'hDEAD_DEAD;
        end
        t = 0;
        @(negedge clk);
        while (!ifb.done && t < 500) begin @(negedge clk); t++; end
        check("b_done_seen", ifb.done, 1);
        repeat (4) @(posedge clk);
        #1;
        ifb.word_valid = 1'b0;
        check("b_shift_count", shifts_b - s0, 40);
        check("b_words_accepted", accepts_b, 2);
        check("b_done_count", dones_b, 1);
        check("b_chain", chain_b, 40'h3C_FFFF_FFFF);

        check("a_readback_all_seen", rb_a.size(), 0);
        check("b_readback_all_seen", rb_b.size(), 0);
        check("a_bits_all_shifted", bits_a.size(), 0);
        check("b_bits_all_shifted", bits_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
